// File: rtl/ms_pkg.sv
// Shared types and sizing for the sequential scalar-product multiplier and its
// downstream dot-product accumulator.
package ms_pkg;

  localparam int unsigned NBITS = 4;
  localparam int unsigned NDATA = 8;

  // Ceiling log2 evaluated at elaboration time
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned PROD_W = 2 * NBITS;
  localparam int unsigned IDX_W  = clog2(NDATA);
  localparam int unsigned ACC_W  = PROD_W + IDX_W;

  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [ACC_W-1:0]  acc_t;
  typedef logic [IDX_W-1:0]  idx_t;

  // Result payload held in the output register
  typedef struct packed {
    logic err;
    acc_t data;
  } dot_t;

endpackage

// File: rtl/dot_accum_seq_if.sv
// Product stream in / dot-product result out; slave is the accumulator's view.
interface dot_accum_seq_if;
  import ms_pkg::*;

  logic  prod_valid;
  logic  prod_ready;
  prod_t prod_data;
  logic  prod_last;
  logic  dot_valid;
  logic  dot_ready;
  acc_t  dot_data;
  logic  dot_err;

  modport master (
    output prod_valid, prod_data, prod_last, dot_ready,
    input  prod_ready, dot_valid, dot_data, dot_err
  );

  modport slave (
    input  prod_valid, prod_data, prod_last, dot_ready,
    output prod_ready, dot_valid, dot_data, dot_err
  );

endinterface

// File: rtl/dot_out_reg.sv
// Result holding register with valid/ready: load wins over take so back-to-back
// frames keep valid high without a bubble.
module dot_out_reg
  import ms_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  dot_t load_data,
  input  logic ready,
  output logic valid,
  output dot_t data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dot_accum_seq.sv
// Accumulates NDATA products per frame into one dot-product; a frame closes on
// the element count or on prod_last, flagging any length mismatch.
module dot_accum_seq
  import ms_pkg::*;
(
  input logic             clk,
  input logic             reset,
  dot_accum_seq_if.slave  bus
);

  idx_t idx;
  acc_t acc;
  acc_t base;
  acc_t sum;
  logic at_end;
  logic closing;
  logic accept;
  logic load;
  logic held_valid;
  dot_t held;
  dot_t load_data;

  always_comb begin
    at_end  = (idx == IDX_W'(NDATA - 1));
    closing = bus.prod_last | at_end;
    base    = (idx == '0) ? '0 : acc;
    sum     = base + ACC_W'(bus.prod_data);
  end

  // Only a closing beat must wait for a free result slot
  assign bus.prod_ready = ~(held_valid & ~bus.dot_ready) | ~closing;
  assign accept         = bus.prod_valid & bus.prod_ready;
  assign load           = accept & closing;
  assign load_data      = '{err: (bus.prod_last != at_end), data: sum};

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      acc <= '0;
    end else if (accept) begin
      acc <= sum;
      idx <= closing ? '0 : idx + IDX_W'(1);
    end
  end

  dot_out_reg u_out (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .ready     (bus.dot_ready),
    .valid     (held_valid),
    .data      (held)
  );

  assign bus.dot_valid = held_valid;
  assign bus.dot_data  = held.data;
  assign bus.dot_err   = held.err;

endmodule

// File: tb/tb_dot_accum_seq.sv
// Directed bench for dot_accum_seq: table of frames plus hand-written
// backpressure and reset sequences.
module tb_dot_accum_seq;
  import ms_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  dot_accum_seq_if bus ();

  dot_accum_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string                   name;
    int                      n;
    logic [7:0][PROD_W-1:0]  beats;
    logic [7:0]              lasts;
    acc_t                    exp_data;
    logic                    exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded)
  task automatic send(input prod_t d, input logic last);
    bit done;
    done = 1'b0;
    bus.prod_valid = 1'b1;
    bus.prod_data  = d;
    bus.prod_last  = last;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.prod_ready) done = 1'b1;
      tick();
    end
    bus.prod_valid = 1'b0;
    bus.prod_last  = 1'b0;
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: got prod_ready=0 expected accept within 20 cycles");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.prod_valid = 1'b0;
    bus.prod_data  = '0;
    bus.prod_last  = 1'b0;
    bus.dot_ready  = 1'b1;

    vecs[0] = '{name: "ramp",   n: 8, beats: {8'd0, 8'd6, 8'd10, 8'd12, 8'd12, 8'd10, 8'd6, 8'd0},
                lasts: 8'h80, exp_data: acc_t'(56),   exp_err: 1'b0};
    vecs[1] = '{name: "max",    n: 8, beats: {8{8'd225}},
                lasts: 8'h80, exp_data: acc_t'(1800), exp_err: 1'b0};
    vecs[2] = '{name: "ones",   n: 8, beats: {8{8'd1}},
                lasts: 8'h80, exp_data: acc_t'(8),    exp_err: 1'b0};
    vecs[3] = '{name: "short",  n: 3, beats: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd5, 8'd5},
                lasts: 8'h04, exp_data: acc_t'(15),   exp_err: 1'b1};
    vecs[4] = '{name: "nolast", n: 8, beats: {8{8'd1}},
                lasts: 8'h00, exp_data: acc_t'(8),    exp_err: 1'b1};
    vecs[5] = '{name: "single", n: 1, beats: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd9},
                lasts: 8'h01, exp_data: acc_t'(9),    exp_err: 1'b1};
    vecs[6] = '{name: "mixed",  n: 8, beats: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                lasts: 8'h80, exp_data: acc_t'(36),   exp_err: 1'b0};

    do_reset();
    chk("rst_valid", 32'(bus.dot_valid), 32'd0);
    chk("rst_data",  32'(bus.dot_data),  32'd0);
    chk("rst_err",   32'(bus.dot_err),   32'd0);
    chk("rst_ready", 32'(bus.prod_ready), 32'd1);

    // Table frames with the consumer always ready
    for (int v = 0; v < 7; v++) begin
      for (int b = 0; b < vecs[v].n; b++) begin
        send(vecs[v].beats[b], vecs[v].lasts[b]);
        if (b < vecs[v].n - 1) chk({vecs[v].name, "_mid_valid"}, 32'(bus.dot_valid), 32'd0);
      end
      chk({vecs[v].name, "_valid"}, 32'(bus.dot_valid), 32'd1);
      chk({vecs[v].name, "_data"},  32'(bus.dot_data),  32'(vecs[v].exp_data));
      chk({vecs[v].name, "_err"},   32'(bus.dot_err),   32'(vecs[v].exp_err));
      tick();
      chk({vecs[v].name, "_pulse"}, 32'(bus.dot_valid), 32'd0);
    end

    // Backpressure: result held while the next frame's closing beat stalls
    bus.dot_ready = 1'b0;
    for (int b = 0; b < 8; b++) send(vecs[0].beats[b], vecs[0].lasts[b]);
    chk("bp_f1_data", 32'(bus.dot_data), 32'd56);
    for (int b = 0; b < 7; b++) send(prod_t'(2), 1'b0);
    chk("bp_f2_valid", 32'(bus.dot_valid), 32'd1);
    chk("bp_f2_held",  32'(bus.dot_data),  32'd56);
    bus.prod_valid = 1'b1;
    bus.prod_data  = prod_t'(2);
    bus.prod_last  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("bp_stall_ready", 32'(bus.prod_ready), 32'd0);
      chk("bp_stall_valid", 32'(bus.dot_valid),  32'd1);
      chk("bp_stall_data",  32'(bus.dot_data),   32'd56);
      tick();
    end
    bus.dot_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(bus.prod_ready), 32'd1);
    tick();
    bus.prod_valid = 1'b0;
    bus.prod_last  = 1'b0;
    chk("bp_f2_valid_cont", 32'(bus.dot_valid), 32'd1);
    chk("bp_f2_data",       32'(bus.dot_data),  32'd16);
    chk("bp_f2_err",        32'(bus.dot_err),   32'd0);
    tick();
    chk("bp_f2_taken", 32'(bus.dot_valid), 32'd0);

    // Reset mid-frame discards the partial sum
    for (int b = 0; b < 4; b++) send(prod_t'(7), 1'b0);
    do_reset();
    for (int b = 0; b < 8; b++) send(prod_t'(2), b == 7);
    chk("rst_mid_valid", 32'(bus.dot_valid), 32'd1);
    chk("rst_mid_data",  32'(bus.dot_data),  32'd16);
    chk("rst_mid_err",   32'(bus.dot_err),   32'd0);

    // Reset while a result is held drops it
    bus.dot_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_held_valid", 32'(bus.dot_valid), 32'd0);
    chk("rst_held_data",  32'(bus.dot_data),  32'd0);
    bus.dot_ready = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
